output_aggregator: RTL and testbench

Collects per-neuron activations from the shared neuron layer as each neuron finishes, and registers them. Presents them back to the input aggregator as layer_input / layer_input_valid for the next layer pass. Owns the current layer index, advancing and wrapping it as each layer completes. Flags the final-layer result as the network output.

---
 rtl/output_aggregator.sv | 95 +++++++++
 tb/tb_output_aggregator.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/output_aggregator.sv
// output_aggregator: collects per-neuron activations for one layer pass and
// feeds them back to the input aggregator. It also tracks the layer index and
// flags the final-layer result as the network output.
//
// Ports:
//   clk                  system clock, rising edge
//   rst                  synchronous active-high reset
//   layer_start          one-cycle pulse that begins a layer pass
//   active               active-neuron mask, latched on layer_start
//   neuron_output        packed activations, slice i = [i*INPUT_SIZE +: INPUT_SIZE]
//   neuron_valid         per-neuron valid for neuron_output
//   layer_output         captured activations (registered)
//   layer_output_valid   per-neuron captured flags (registered)
//   layer                current layer index (registered)
//   network_output_valid one-cycle pulse when layer_output holds the final layer
//   busy                 high while collecting a layer
module output_aggregator #(
  parameter int unsigned LAYER_MAX  = 3,
  parameter int unsigned NUM_NEURON = 6,
  parameter int unsigned INPUT_SIZE = 9
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             layer_start,
  input  logic [NUM_NEURON-1:0]            active,
  input  logic [NUM_NEURON*INPUT_SIZE-1:0] neuron_output,
  input  logic [NUM_NEURON-1:0]            neuron_valid,
  output logic [NUM_NEURON*INPUT_SIZE-1:0] layer_output,
  output logic [NUM_NEURON-1:0]            layer_output_valid,
  output logic [$clog2(LAYER_MAX):0]       layer,
  output logic                             network_output_valid,
  output logic                             busy
);

  localparam int unsigned LAYER_W = $clog2(LAYER_MAX) + 1;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                state;
  logic [NUM_NEURON-1:0] mask;
  logic [NUM_NEURON-1:0] cap;
  logic [NUM_NEURON-1:0] next_valid;
  logic                  done;

  // Capture enables and completion, evaluated on the post-capture flags so
  // the last capture edge also ends the layer. A start pulse suppresses capture.
  always_comb begin
    cap = '0;
    if (state == COLLECT && !layer_start) begin
      cap = neuron_valid & mask & ~layer_output_valid;
    end
    next_valid = layer_output_valid | cap;
    done       = ((next_valid & mask) == mask);
  end

  // State, capture registers and layer bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      mask                 <= '0;
      layer_output         <= '0;
      layer_output_valid   <= '0;
      layer                <= '0;
      network_output_valid <= 1'b0;
      busy                 <= 1'b0;
    end else begin
      network_output_valid <= 1'b0;
      if (layer_start) begin
        // Starts (and restarts) keep old data; only the flags are cleared.
        mask               <= active;
        layer_output_valid <= '0;
        state              <= COLLECT;
        busy               <= 1'b1;
      end else if (state == COLLECT) begin
        for (int unsigned i = 0; i < NUM_NEURON; i++) begin
          if (cap[i]) begin
            layer_output[i*INPUT_SIZE +: INPUT_SIZE] <= neuron_output[i*INPUT_SIZE +: INPUT_SIZE];
          end
        end
        layer_output_valid <= next_valid;
        if (done) begin
          state <= IDLE;
          busy  <= 1'b0;
          if (layer == LAYER_W'(LAYER_MAX - 1)) begin
            layer                <= '0;
            network_output_valid <= 1'b1;
          end else begin
            layer <= layer + LAYER_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_output_aggregator.sv
// Bench for output_aggregator: random and directed stimulus, a per-cycle
// reference model feeding an expectation queue, and an independent monitor.
module tb_output_aggregator;

  localparam int unsigned LM = 3;
  localparam int unsigned NN = 6;
  localparam int unsigned IS = 9;
  localparam int unsigned DW = NN * IS;
  localparam int unsigned LW = $clog2(LM) + 1;

  logic          clk = 1'b1;
  logic          rst = 1'b1;
  logic          layer_start = 1'b0;
  logic [NN-1:0] active = '0;
  logic [DW-1:0] neuron_output = '0;
  logic [NN-1:0] neuron_valid = '0;
  logic [DW-1:0] layer_output;
  logic [NN-1:0] layer_output_valid;
  logic [LW-1:0] layer;
  logic          network_output_valid;
  logic          busy;

  output_aggregator #(.LAYER_MAX(LM), .NUM_NEURON(NN), .INPUT_SIZE(IS)) dut (
    .clk(clk), .rst(rst), .layer_start(layer_start), .active(active),
    .neuron_output(neuron_output), .neuron_valid(neuron_valid),
    .layer_output(layer_output), .layer_output_valid(layer_output_valid),
    .layer(layer), .network_output_valid(network_output_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] lo;
    logic [NN-1:0] lov;
    int            lay;
    logic          nov;
    logic          bsy;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: plain per-neuron arrays and an integer layer counter.
  bit            m_got[NN];
  logic [IS-1:0] m_dat[NN];
  bit            m_use[NN];
  int            m_layer = 0;
  bit            m_coll = 0;
  bit            m_nov = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit s, input logic [NN-1:0] a,
                       input logic [NN-1:0] v, input logic [DW-1:0] d);
    bit all_in;
    exp_t e;
    if (r) begin
      for (int i = 0; i < NN; i++) begin
        m_got[i] = 0; m_dat[i] = '0; m_use[i] = 0;
      end
      m_layer = 0; m_coll = 0; m_nov = 0;
    end else begin
      m_nov = 0;
      if (s) begin
        for (int i = 0; i < NN; i++) begin
          m_use[i] = a[i]; m_got[i] = 0;
        end
        m_coll = 1;
      end else if (m_coll) begin
        all_in = 1;
        for (int i = 0; i < NN; i++) begin
          if (v[i] && m_use[i] && !m_got[i]) begin
            m_got[i] = 1;
            m_dat[i] = d[i*IS +: IS];
          end
          if (m_use[i] && !m_got[i]) all_in = 0;
        end
        if (all_in) begin
          m_coll = 0;
          if (m_layer == LM - 1) begin
            m_layer = 0; m_nov = 1;
          end else begin
            m_layer = m_layer + 1;
          end
        end
      end
    end
    for (int i = 0; i < NN; i++) begin
      e.lo[i*IS +: IS] = m_dat[i];
      e.lov[i] = m_got[i];
    end
    e.lay = m_layer;
    e.nov = m_nov;
    e.bsy = m_coll;
    q.push_back(e);
  endtask

  // Drive one cycle, update the model, then land just after the clock edge.
  task automatic step(input bit r, input bit s, input logic [NN-1:0] a,
                      input logic [NN-1:0] v, input logic [DW-1:0] d);
    @(negedge clk);
    rst = r; layer_start = s; active = a; neuron_valid = v; neuron_output = d;
    model(r, s, a, v, d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, '0, '0, DW'($urandom()) ^ {DW{1'b1}});
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < NN; i++) d[i*IS +: IS] = IS'($urandom());
    return d;
  endfunction

  // Monitor: every cycle the DUT presents registered outputs; compare to queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL monitor_underflow: no expectation queued at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("layer_output", 64'(layer_output), 64'(e.lo));
        chk("layer_output_valid", 64'(layer_output_valid), 64'(e.lov));
        chk("layer", 64'(layer), 64'(e.lay));
        chk("network_output_valid", 64'(network_output_valid), 64'(e.nov));
        chk("busy", 64'(busy), 64'(e.bsy));
      end
    end
  end

  initial begin
    logic [DW-1:0] d;
    logic [LW-1:0] saved_layer;
    int pulses;

    // Reset
    step(1, 0, '0, '0, '0);
    step(1, 0, '0, '0, '0);
    chk("reset_layer", 64'(layer), 64'd0);
    chk("reset_lov", 64'(layer_output_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);

    // Fill one neuron per cycle
    step(0, 1, 6'b111111, '0, '0);
    for (int i = 0; i < NN; i++) begin
      d = '0;
      d[i*IS +: IS] = IS'(9'h010 + i);
      step(0, 0, '0, NN'(1 << i), d);
      chk("fill_lov", 64'(layer_output_valid), 64'((1 << (i + 1)) - 1));
    end
    chk("fill_layer", 64'(layer), 64'd1);
    chk("fill_busy", 64'(busy), 64'd0);
    chk("fill_slice3", 64'(layer_output[3*IS +: IS]), 64'h013);

    // Three full passes from reset: 0 -> 1 -> 2 -> 0 with network pulse
    step(1, 0, '0, '0, '0);
    for (int p = 0; p < 3; p++) begin
      step(0, 1, 6'b111111, '0, '0);
      d = rand_data();
      step(0, 0, '0, 6'b111111, d);
      chk("pass_layer", 64'(layer), 64'((p + 1) % 3));
      chk("pass_nov", 64'(network_output_valid), 64'(p == 2));
    end
    chk("pass3_data", 64'(layer_output), 64'(d));
    idle();
    chk("nov_one_cycle", 64'(network_output_valid), 64'd0);

    // Masked-off valids ignored
    step(0, 1, 6'b000111, '0, '0);
    step(0, 0, '0, 6'b111000, rand_data());
    chk("masked_ignored", 64'(layer_output_valid), 64'd0);
    chk("masked_busy", 64'(busy), 64'd1);
    step(0, 0, '0, 6'b000111, rand_data());
    chk("masked_done", 64'(layer_output_valid), 64'b000111);
    chk("masked_idle", 64'(busy), 64'd0);

    // Repeat pulse keeps first value
    step(0, 1, 6'b111111, '0, '0);
    d = '0; d[2*IS +: IS] = 9'h055;
    step(0, 0, '0, 6'b000100, d);
    d = '0; d[2*IS +: IS] = 9'h0AA;
    step(0, 0, '0, 6'b000100, d);
    chk("first_kept", 64'(layer_output[2*IS +: IS]), 64'h055);

    // Mid-pass restart with a same-cycle valid
    step(0, 1, 6'b111111, '0, '0);
    step(0, 0, '0, 6'b000001, rand_data());
    step(0, 0, '0, 6'b000010, rand_data());
    saved_layer = layer;
    step(0, 1, 6'b111111, 6'b000100, rand_data());
    chk("restart_lov", 64'(layer_output_valid), 64'd0);
    chk("restart_layer", 64'(layer), 64'(saved_layer));
    chk("restart_busy", 64'(busy), 64'd1);

    // Empty mask completes one cycle after start
    saved_layer = layer;
    step(0, 1, '0, '0, '0);
    chk("empty_busy", 64'(busy), 64'd1);
    idle();
    chk("empty_done", 64'(busy), 64'd0);
    chk("empty_layer", 64'(layer), 64'((int'(saved_layer) + 1) % 3));

    // Reset mid-collect with valids high
    step(0, 1, 6'b111111, '0, '0);
    step(0, 0, '0, 6'b000001, rand_data());
    step(1, 0, '0, 6'b111111, rand_data());
    chk("rst_lo", 64'(layer_output), 64'd0);
    chk("rst_lov", 64'(layer_output_valid), 64'd0);
    chk("rst_layer", 64'(layer), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // Random traffic
    pulses = 0;
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
           NN'($urandom()), NN'($urandom()) & NN'($urandom()), rand_data());
      if (network_output_valid) pulses++;
    end
    chk("random_saw_network_output", 64'(pulses > 0), 64'd1);

    #2;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
